uart_rx_mmio: RTL and testbench
===============================

Name: uart_rx_mmio

Overview:
Memory-mapped UART receiver peripheral. It is the receive-side counterpart of the SOC's transmit-only emitter UART and sits on the same CPU data bus in the UART address window.
- Deserialises 8N1 frames from RXD.
- Buffers received bytes in a small FIFO.
- Exposes DATA and STATUS registers to the processor, with one-cycle registered read latency, matching RAM timing.

Parameters:
- CLK_FREQ_HZ, 12000000: system clock frequency.
- BAUD_RATE, 9600: line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, integer division; must be >= 4.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of two, >= 2.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- rxd  in  1  asynchronous serial input, idle high
- bus_valid  in  1  access targets this peripheral (address decode done in SOC)
- bus_rstrb  in  1  read strobe; qualified by bus_valid
- bus_we  in  1  write strobe; qualified by bus_valid
- bus_addr  in  32  byte address; only bits [3:2] decoded
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- rx_irq  out  1  high while FIFO is non-empty

Behaviour:
Reset (resetn=0 at clk edge):
- FSM goes to IDLE. FIFO is emptied. Sticky flags are cleared.
- bus_rdata=0, rx_irq=0, synchroniser flops set to 1.
- A frame in progress is discarded.

Input synchronisation:
- rxd passes through a 2-flop synchroniser; the output is rx_s.
- All FSM decisions use rx_s only.

Receive FSM:
- Uses cnt, a baud counter wide enough for CLKS_PER_BIT-1, and bitidx[2:0].
- IDLE: when rx_s==0, load cnt=CLKS_PER_BIT/2-1 and go to START.
- START: decrement cnt. At cnt==0:
  - if rx_s==0, load cnt=CLKS_PER_BIT-1, bitidx=0, go to DATA;
  - otherwise treat as a glitch and go back to IDLE.
- DATA: at cnt==0:
  - shift rx_s into shreg MSB (LSB-first line order);
  - reload cnt=CLKS_PER_BIT-1;
  - after bitidx==7 go to STOP, else increment bitidx.
- STOP: at cnt==0, sample rx_s.
  - rx_s==1: push shreg into FIFO. If the FIFO is full, drop the byte, set OVR=1, leave FIFO contents unchanged. Go to IDLE.
  - rx_s==0: set FERR=1, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: remain until rx_s==1, then go to IDLE. This prevents a break condition from retriggering.

FIFO:
- Circular buffer with rd/wr pointers and a count of 0..FIFO_DEPTH.
- Push and pop in the same cycle: both happen, count unchanged. This holds when full too, because the pop frees a slot first, so no overrun is flagged.
- Pointers wrap modulo FIFO_DEPTH.

Register map (offset = bus_addr[3:2]*4):
- 0x0 DATA (read):
  - bus_rdata <= {24'b0, fifo head} and pop, only if non-empty.
  - If empty, bus_rdata <= 0 and no pop.
- 0x4 STATUS (read): bus_rdata <= {28'b0, FERR, OVR, full, !empty}.
- 0x4 STATUS (write): a 1 in bus_wdata[2] clears OVR; a 1 in bus_wdata[3] clears FERR. A clear and a set in the same cycle leave the flag set.
- 0x0 write, 0x8 and 0xC: writes ignored, reads return 0.

Read timing:
- bus_rdata updates on the clk edge where bus_valid & bus_rstrb is high, and holds otherwise.
- Data is valid the cycle after the strobe.
- The pop takes effect on the same edge; count is decremented the next cycle.

rx_irq:
- Combinational (count != 0).

Test Plan:
Bench uses CLK_FREQ_HZ=1000, BAUD_RATE=100 (CLKS_PER_BIT=10), FIFO_DEPTH=4.
- Single frame: drive 0x55 as 8N1 at 10 clk/bit → rx_irq rises after the stop-bit sample. STATUS read = 0x1; DATA read = 0x00000055; then STATUS = 0x0 and rx_irq=0.
- Back-to-back frames 0x01,0x80,0xFF,0x3C with no reads → STATUS = 0x3 (full). A 5th frame 0xA5 → STATUS = 0x7. DATA reads return 01,80,FF,3C in order; a 5th DATA read returns 0. Writing 0x4 to STATUS → OVR cleared.
- Framing error: send 0x42 with stop bit 0, hold rx low 30 clk, then high → FIFO stays empty, STATUS = 0x8. A following valid 0x42 is received correctly. Writing 0x8 to STATUS → 0x0.
- Glitch rejection: pulse rxd low for 3 clk, then hold high → no byte received, FSM back in IDLE, STATUS = 0x0.
- Simultaneous push/pop: FIFO full, issue a DATA read on the exact cycle the stop-bit sample pushes → count stays 4, OVR=0. Data returned is the oldest byte.
- Reset mid-frame: assert resetn=0 for 1 clk during bit 3 of a frame, then send 0x9A → only 0x9A is received. bus_rdata reads 0 immediately after reset.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with a small FIFO and DATA/STATUS registers.
module uart_rx_mmio #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  input  logic        bus_valid,
  input  logic        bus_rstrb,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        rx_irq
);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bitidx;
  logic [7:0] r_shreg;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic r_ovr, r_ferr;
  logic w_rx_s, w_tick, w_stop_ok, w_stop_bad, w_rd, w_wr_stat;
  logic w_empty, w_full, w_pop, w_push, w_ovr_set;
  logic [1:0] w_sel;
  logic w_unused;
  assign w_rx_s = r_sync[1];
  assign rx_irq = !w_empty;
  assign w_unused = &{1'b0, bus_addr[31:4], bus_addr[1:0], bus_wdata[31:4], bus_wdata[1:0]};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_sync <= 2'b11;
    end else begin
      r_state <= w_next;
      r_sync <= {r_sync[0], rxd};
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_rx_s ? IDLE : START;
      START:     w_next = !w_tick ? START : w_rx_s ? IDLE : DATA;
      DATA:      w_next = (w_tick && r_bitidx == 3'd7) ? STOP : DATA;
      STOP:      w_next = !w_tick ? STOP : w_rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: w_next = w_rx_s ? IDLE : WAIT_HIGH;
      default:   w_next = IDLE;
    endcase
  end
  // A full FIFO still accepts a byte when a DATA read pops on the same edge.
  always_comb begin
    w_tick = r_cnt == '0;
    w_stop_ok = r_state == STOP && w_tick && w_rx_s;
    w_stop_bad = r_state == STOP && w_tick && !w_rx_s;
    w_sel = bus_addr[3:2];
    w_rd = bus_valid && bus_rstrb;
    w_wr_stat = bus_valid && bus_we && w_sel == 2'd1;
    w_empty = r_count == '0;
    w_full = r_count == (AW+1)'(FIFO_DEPTH);
    w_pop = w_rd && w_sel == 2'd0 && !w_empty;
    w_push = w_stop_ok && (!w_full || w_pop);
    w_ovr_set = w_stop_ok && w_full && !w_pop;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_bitidx <= '0;
      r_shreg <= '0;
    end else begin
      r_cnt <= r_state == IDLE ? HALF : w_tick ? FULL : r_cnt - CW'(1);
      r_bitidx <= r_state == START ? '0 : (r_state == DATA && w_tick) ? r_bitidx + 3'd1 : r_bitidx;
      r_shreg <= (r_state == DATA && w_tick) ? {w_rx_s, r_shreg[7:1]} : r_shreg;
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= r_shreg;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_ovr <= 1'b0;
      r_ferr <= 1'b0;
      bus_rdata <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovr <= w_ovr_set || (r_ovr && !(w_wr_stat && bus_wdata[2]));
      r_ferr <= w_stop_bad || (r_ferr && !(w_wr_stat && bus_wdata[3]));
      if (w_rd)
        bus_rdata <= w_sel == 2'd0 ? {24'b0, w_pop ? r_mem[r_rp] : 8'h00} :
                     w_sel == 2'd1 ? {28'b0, r_ferr, r_ovr, w_full, !w_empty} : '0;
    end
  end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: drives 8N1 frames and bus accesses, compares against a queue-based model.
module tb_uart_rx_mmio;
  logic clk = 0, resetn = 0, rxd = 1, bus_valid = 0, bus_rstrb = 0, bus_we = 0;
  logic [31:0] bus_addr = 0, bus_wdata = 0, bus_rdata;
  logic rx_irq;
  int n_pass = 0, n_tot = 0;
  logic [7:0] q[$];
  logic m_ovr = 0, m_ferr = 0;

  uart_rx_mmio #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd), .bus_valid(bus_valid), .bus_rstrb(bus_rstrb),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .rx_irq(rx_irq));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [31:0] m_status();
    return {28'b0, m_ferr, m_ovr, q.size() == 4, q.size() != 0};
  endfunction

  function automatic logic [31:0] m_data();
    if (q.size() == 0) return 32'h0;
    return {24'b0, q.pop_front()};
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line-level frame; the model sees the byte once the whole frame has been sent.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      tick_n(10);
    end
    if (!stop) m_ferr = 1;
    else if (q.size() == 4) m_ovr = 1;
    else q.push_back(b);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_valid = 1; bus_rstrb = 1; bus_addr = a;
    tick_n(1);
    bus_valid = 0; bus_rstrb = 0;
    d = bus_rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
    bus_valid = 1; bus_we = 1; bus_addr = a; bus_wdata = w;
    tick_n(1);
    bus_valid = 0; bus_we = 0;
    if (a[3:2] == 2'd1 && w[2]) m_ovr = 0;
    if (a[3:2] == 2'd1 && w[3]) m_ferr = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    resetn = 0;
    tick_n(3);
    resetn = 1;
    tick_n(2);
    n_tot++; if (bus_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bus_rdata); else n_pass++;
    n_tot++; if (rx_irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", rx_irq); else n_pass++;
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL reset_status got=%h exp=%h", d, e); else n_pass++;
    bus_read(32'h0, d); e = m_data();
    n_tot++; if (d !== e) $display("FAIL reset_data got=%h exp=%h", d, e); else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] d, e;
    fork
      send_frame(8'h55, 1);
      begin
        tick_n(97);
        n_tot++; if (rx_irq !== 1'b0) $display("FAIL single_irq_pre got=%b exp=0", rx_irq); else n_pass++;
        tick_n(1);
        n_tot++; if (rx_irq !== 1'b1) $display("FAIL single_irq_post got=%b exp=1", rx_irq); else n_pass++;
      end
    join
    tick_n(2);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL single_status got=%h exp=%h", d, e); else n_pass++;
    bus_read(32'h0, d); e = m_data();
    n_tot++; if (d !== e) $display("FAIL single_data got=%h exp=%h", d, e); else n_pass++;
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL single_status_after got=%h exp=%h", d, e); else n_pass++;
    n_tot++; if (rx_irq !== 1'b0) $display("FAIL single_irq_after got=%b exp=0", rx_irq); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    logic [7:0] bytes [4] = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1);
    tick_n(2);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL b2b_full got=%h exp=%h", d, e); else n_pass++;
    send_frame(8'hA5, 1);
    tick_n(2);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL b2b_ovr got=%h exp=%h", d, e); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      bus_read(32'h0, d); e = m_data();
      n_tot++; if (d !== e) $display("FAIL b2b_data%0d got=%h exp=%h", i, d, e); else n_pass++;
    end
    bus_read(32'h8, d);
    n_tot++; if (d !== 32'h0) $display("FAIL b2b_addr8 got=%h exp=0", d); else n_pass++;
    bus_write(32'h4, 32'h4);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL b2b_ovr_clear got=%h exp=%h", d, e); else n_pass++;
  endtask

  task automatic test_framing();
    logic [31:0] d, e;
    send_frame(8'h42, 0);
    tick_n(30);
    rxd = 1;
    tick_n(20);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL ferr_status got=%h exp=%h", d, e); else n_pass++;
    n_tot++; if (rx_irq !== 1'b0) $display("FAIL ferr_irq got=%b exp=0", rx_irq); else n_pass++;
    send_frame(8'h42, 1);
    tick_n(2);
    bus_read(32'h0, d); e = m_data();
    n_tot++; if (d !== e) $display("FAIL ferr_next_data got=%h exp=%h", d, e); else n_pass++;
    bus_write(32'h4, 32'h8);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL ferr_clear got=%h exp=%h", d, e); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    rxd = 0;
    tick_n(3);
    rxd = 1;
    tick_n(30);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL glitch_status got=%h exp=%h", d, e); else n_pass++;
    send_frame(8'h5A, 1);
    tick_n(2);
    bus_read(32'h0, d); e = m_data();
    n_tot++; if (d !== e) $display("FAIL glitch_next_data got=%h exp=%h", d, e); else n_pass++;
  endtask

  task automatic test_push_pop();
    logic [31:0] d, e;
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1);
    tick_n(2);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL pp_full got=%h exp=%h", d, e); else n_pass++;
    fork
      send_frame(8'($urandom), 1);
      begin
        tick_n(97);
        bus_read(32'h0, d); e = m_data();
        n_tot++; if (d !== e) $display("FAIL pp_oldest got=%h exp=%h", d, e); else n_pass++;
      end
    join
    tick_n(2);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL pp_status got=%h exp=%h", d, e); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h0, d); e = m_data();
      n_tot++; if (d !== e) $display("FAIL pp_drain%0d got=%h exp=%h", i, d, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic [9:0] bits;
    send_frame(8'h11, 1);
    tick_n(2);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL rmid_pre got=%h exp=%h", d, e); else n_pass++;
    bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rxd = bits[i];
      tick_n(10);
    end
    rxd = bits[4];
    tick_n(5);
    resetn = 0;
    tick_n(1);
    resetn = 1;
    q.delete(); m_ovr = 0; m_ferr = 0;
    n_tot++; if (bus_rdata !== 32'h0) $display("FAIL rmid_rdata got=%h exp=0", bus_rdata); else n_pass++;
    n_tot++; if (rx_irq !== 1'b0) $display("FAIL rmid_irq got=%b exp=0", rx_irq); else n_pass++;
    rxd = 1;
    tick_n(20);
    send_frame(8'h9A, 1);
    tick_n(2);
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL rmid_status got=%h exp=%h", d, e); else n_pass++;
    bus_read(32'h0, d); e = m_data();
    n_tot++; if (d !== e) $display("FAIL rmid_data got=%h exp=%h", d, e); else n_pass++;
    bus_read(32'h4, d); e = m_status();
    n_tot++; if (d !== e) $display("FAIL rmid_empty got=%h exp=%h", d, e); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d, e, w;
    logic stop;
    for (int it = 0; it < 12; it++) begin
      stop = $urandom_range(0, 4) != 0;
      send_frame(8'($urandom), stop);
      rxd = 1;
      tick_n($urandom_range(2, 12));
      case ($urandom_range(0, 3))
        0, 1: begin
          bus_read(32'h0, d); e = m_data();
          n_tot++; if (d !== e) $display("FAIL rnd_data%0d got=%h exp=%h", it, d, e); else n_pass++;
        end
        2: begin
          bus_read(32'h4, d); e = m_status();
          n_tot++; if (d !== e) $display("FAIL rnd_status%0d got=%h exp=%h", it, d, e); else n_pass++;
        end
        default: begin
          w = $urandom;
          bus_write(32'h4, w);
          bus_read(32'h4, d); e = m_status();
          n_tot++; if (d !== e) $display("FAIL rnd_clear%0d got=%h exp=%h", it, d, e); else n_pass++;
        end
      endcase
      n_tot++; if (rx_irq !== (q.size() != 0)) $display("FAIL rnd_irq%0d got=%b exp=%b", it, rx_irq, q.size() != 0); else n_pass++;
    end
    while (q.size() != 0) begin
      bus_read(32'h0, d); e = m_data();
      n_tot++; if (d !== e) $display("FAIL rnd_drain got=%h exp=%h", d, e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
